// File: rtl/gshare_branch_predictor_pkg.sv
// Shared state encoding and counter helpers for the gshare branch predictor.
// Counter helpers work on a widened value so one function serves any CTR_W up to CTR_MAX_W.
package bp_pkg;

    localparam int CTR_MAX_W = 8;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Weakly-not-taken: one below the taken/not-taken midpoint.
    function automatic logic [CTR_MAX_W-1:0] wnt(input int ctr_w);
        return CTR_MAX_W'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] sat_update(input logic [CTR_MAX_W-1:0] ctr,
                                                        input logic                 taken,
                                                        input int                   ctr_w);
        logic [CTR_MAX_W-1:0] ctr_max;
        ctr_max = CTR_MAX_W'((1 << ctr_w) - 1);
        if (taken) begin
            return (ctr == ctr_max) ? ctr : ctr + CTR_MAX_W'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Predict/resolve bus between the fetch/execute stages (master) and the predictor (slave).
// pred_valid and upd_valid are single-cycle strobes with no backpressure; ready only says
// results are meaningful, and every prediction output is combinational from the same cycle.
interface gshare_branch_predictor_if #(
    parameter int PC_W  = 8,
    parameter int GHR_W = 4
);
    logic             ready;
    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_taken;
    logic             pred_hit;
    logic [PC_W-1:0]  pred_target;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_pred_taken;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;
    logic             flush;

    modport master (
        input  ready, pred_taken, pred_hit, pred_target, pred_ghr, flush,
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_pred_taken,
               upd_taken, upd_target
    );

    modport slave (
        output ready, pred_taken, pred_hit, pred_target, pred_ghr, flush,
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_pred_taken,
               upd_taken, upd_target
    );
endinterface

// File: rtl/gshare_branch_predictor_btb.sv
// Direct-mapped tagged branch target buffer: combinational lookup, one clocked write port,
// and a clear port that invalidates one entry per cycle during the init sweep.
module bp_btb #(
    parameter int PC_W  = 8,
    parameter int IDX_W = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [PC_W-1:0]  rd_target
);
    localparam int DEPTH = 1 << IDX_W;

    logic             valid   [DEPTH];
    logic [TAG_W-1:0] tags    [DEPTH];
    logic [PC_W-1:0]  targets [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid[wr_idx]   <= 1'b1;
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
    end

    assign hit       = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_target = hit ? targets[rd_idx] : '0;
endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a tagged BTB; define GSHARE_EN for history hashing,
// otherwise it runs as a plain bimodal predictor with the history held at zero.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IDX_W = 4,
    parameter int CTR_W = 2,
    parameter int GHR_W = 4,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    gshare_branch_predictor_if.slave  bus,
    output bp_state_e                 fsm_state
);
    localparam int DEPTH = 1 << IDX_W;

    bp_state_e        state;
    bp_state_e        state_next;
    logic [IDX_W-1:0] sweep;
    logic [CTR_W-1:0] ctr [DEPTH];
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] pidx;
    logic [IDX_W-1:0] uidx;
    logic             run;
    logic             pred_taken_int;
    logic             flush_int;
    logic             btb_hit;
    logic [PC_W-1:0]  btb_target;

    assign run = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (sweep == '1) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep <= '0;
        end else if (!run) begin
            sweep <= sweep + IDX_W'(1);
        end
    end

`ifdef GSHARE_EN
    assign pidx = bus.pred_pc[IDX_W-1:0] ^ IDX_W'(ghr);
    assign uidx = bus.upd_pc[IDX_W-1:0] ^ IDX_W'(bus.upd_ghr);

    // Recovery from a mispredict outranks the speculative shift of the same cycle.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            ghr <= '0;
        end else if (flush_int) begin
            ghr <= {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
        end else if (bus.pred_valid) begin
            ghr <= {ghr[GHR_W-2:0], pred_taken_int};
        end
    end
`else
    logic unused_upd_ghr;

    assign pidx           = bus.pred_pc[IDX_W-1:0];
    assign uidx           = bus.upd_pc[IDX_W-1:0];
    assign ghr            = '0;
    assign unused_upd_ghr = ^bus.upd_ghr;
`endif

    // The sweep re-arms every counter after reset; resolves only land once running.
    always_ff @(posedge clk) begin
        if (!run) begin
            ctr[sweep] <= CTR_W'(wnt(CTR_W));
        end else if (bus.upd_valid) begin
            ctr[uidx] <= CTR_W'(sat_update(CTR_MAX_W'(ctr[uidx]), bus.upd_taken, CTR_W));
        end
    end

    bp_btb #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk       (clk),
        .clr_en    (!run),
        .clr_idx   (sweep),
        .wr_en     (run && bus.upd_valid && bus.upd_taken),
        .wr_idx    (bus.upd_pc[IDX_W-1:0]),
        .wr_tag    (bus.upd_pc[IDX_W+TAG_W-1:IDX_W]),
        .wr_target (bus.upd_target),
        .rd_idx    (bus.pred_pc[IDX_W-1:0]),
        .rd_tag    (bus.pred_pc[IDX_W+TAG_W-1:IDX_W]),
        .hit       (btb_hit),
        .rd_target (btb_target)
    );

    assign pred_taken_int  = run && ctr[pidx][CTR_W-1];
    assign flush_int       = run && bus.upd_valid && (bus.upd_pred_taken != bus.upd_taken);

    assign bus.ready       = run;
    assign bus.pred_taken  = pred_taken_int;
    assign bus.pred_hit    = run && btb_hit;
    assign bus.pred_target = run ? btb_target : '0;
    assign bus.pred_ghr    = ghr;
    assign bus.flush       = flush_int;
    assign fsm_state       = state;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor: directed vector table, init/reset and history-recovery
// sequences, and randomized traffic compared against an array-based reference model.
module tb_gshare_branch_predictor;
    import bp_pkg::*;

    localparam int PC_W  = 8;
    localparam int IDX_W = 4;
    localparam int CTR_W = 2;
    localparam int GHR_W = 4;
    localparam int TAG_W = 4;
    localparam int DEPTH = 16;
    localparam int CTR_TOP = 3;
    localparam int PKT_W = 16;
`ifdef GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic      clk = 1'b0;
    logic      reset;
    bp_state_e fsm_state;

    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.PC_W(PC_W), .GHR_W(GHR_W)) bus ();

    gshare_branch_predictor #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W),
        .CTR_W (CTR_W),
        .GHR_W (GHR_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [PKT_W-1:0] exp_q[$];
    logic [PKT_W-1:0] obs;

    // Reference model: plain integer arrays indexed by table slot.
    int m_ctr   [DEPTH];
    bit m_valid [DEPTH];
    int m_tag   [DEPTH];
    int m_tgt   [DEPTH];
    int m_ghr;
    int m_init_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic int m_pidx();
        int base;
        base = int'(bus.pred_pc) % DEPTH;
        return GSHARE ? (base ^ m_ghr) : base;
    endfunction

    function automatic bit m_taken();
        return (m_init_left == 0) && (m_ctr[m_pidx()] >= (CTR_TOP + 1) / 2);
    endfunction

    function automatic logic [PKT_W-1:0] model_expect();
        int slot;
        bit run;
        bit hit;
        int tgt;
        bit fl;
        run  = (m_init_left == 0);
        slot = int'(bus.pred_pc) % DEPTH;
        hit  = run && m_valid[slot] && (m_tag[slot] == (int'(bus.pred_pc) / DEPTH) % 16);
        tgt  = hit ? m_tgt[slot] : 0;
        fl   = run && bus.upd_valid && (bus.upd_pred_taken != bus.upd_taken);
        return {run, m_taken(), hit, 8'(tgt), 4'(m_ghr), fl};
    endfunction

    task automatic model_edge();
        int  uidx;
        int  slot;
        bit  tk;
        bit  fl;
        if (reset) begin
            m_init_left = DEPTH;
            m_ghr       = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_ctr[i]   = 1;
                m_valid[i] = 1'b0;
            end
            return;
        end
        if (m_init_left > 0) begin
            m_init_left--;
            return;
        end
        tk = m_taken();
        fl = bus.upd_valid && (bus.upd_pred_taken != bus.upd_taken);
        if (bus.upd_valid) begin
            slot = int'(bus.upd_pc) % DEPTH;
            uidx = GSHARE ? (slot ^ int'(bus.upd_ghr)) : slot;
            if (bus.upd_taken) begin
                m_ctr[uidx]  = (m_ctr[uidx] < CTR_TOP) ? m_ctr[uidx] + 1 : CTR_TOP;
                m_valid[slot] = 1'b1;
                m_tag[slot]   = (int'(bus.upd_pc) / DEPTH) % 16;
                m_tgt[slot]   = int'(bus.upd_target);
            end else begin
                m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
            end
        end
        if (GSHARE) begin
            if (fl) m_ghr = (int'(bus.upd_ghr) * 2 + int'(bus.upd_taken)) % 16;
            else if (bus.pred_valid) m_ghr = (m_ghr * 2 + int'(tk)) % 16;
        end
    endtask

    // One clock: sample and score at the falling edge, advance the model, then the DUT edge.
    task automatic step();
        logic [PKT_W-1:0] exp_v;
        @(negedge clk);
        obs = {bus.ready, bus.pred_taken, bus.pred_hit, bus.pred_target, bus.pred_ghr, bus.flush};
        if (!reset) begin
            exp_q.push_back(model_expect());
            exp_v = exp_q.pop_front();
            check("model", obs, exp_v);
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit pv, input logic [7:0] ppc, input bit uv, input logic [7:0] upc,
                         input logic [3:0] ughr, input bit upt, input bit ut, input logic [7:0] utgt);
        bus.pred_valid     = pv;
        bus.pred_pc        = ppc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_ghr        = ughr;
        bus.upd_pred_taken = upt;
        bus.upd_taken      = ut;
        bus.upd_target     = utgt;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rand_inputs();
        drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    endtask

    task automatic reset_and_wait(input string tag);
        reset = 1'b1;
        rand_inputs();
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            rand_inputs();
            step();
            check($sformatf("%s_ready_c%0d", tag, k), obs[15], 32'(k == DEPTH + 1));
            if (k <= DEPTH) begin
                check($sformatf("%s_init_outs_c%0d", tag, k), {obs[14:5], obs[0]}, 0);
            end
        end
        idle();
    endtask

    task automatic scan_clean(input string tag);
        logic [7:0] pcs[$];
        for (int i = 0; i < DEPTH; i++) pcs.push_back(8'(i));
        pcs.push_back(8'h25);
        pcs.push_back(8'h15);
        foreach (pcs[j]) begin
            drive(1'b0, pcs[j], 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
            step();
            check($sformatf("%s_pc%02h", tag, pcs[j]), obs[14:5], 0);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         pv;
        logic [7:0] ppc;
        bit         uv;
        logic [7:0] upc;
        logic [3:0] ughr;
        bit         upt;
        bit         ut;
        logic [7:0] utgt;
        bit         e_taken;
        bit         e_hit;
        logic [7:0] e_tgt;
        bit         e_flush;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit pv, input logic [7:0] ppc, input bit uv, input logic [7:0] upc,
                       input logic [3:0] ughr, input bit upt, input bit ut, input logic [7:0] utgt,
                       input bit et, input bit eh, input logic [7:0] etgt, input bit ef);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.uv = uv; v.upc = upc; v.ughr = ughr;
        v.upt = upt; v.ut = ut; v.utgt = utgt;
        v.e_taken = et; v.e_hit = eh; v.e_tgt = etgt; v.e_flush = ef;
        vecs.push_back(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // Full init, then a reset landing mid-sweep must restart the count.
        reset_and_wait("init");
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_inputs();
            step();
            check("midinit_ready", obs[15], 0);
        end
        reset_and_wait("reinit");
        scan_clean("fresh");

        // Bimodal training at 0x05 (drain vectors shift zeros back into any history).
        add(0, 8'h05, 1, 8'h05, 4'h0, 0, 1, 8'h40, 0, 0, 8'h00, 1);
        add(0, 8'h0F, 1, 8'h05, 4'h0, 0, 1, 8'h40, 0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) add(1, 8'h0F, 0, 8'h00, 4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(0, 8'h05, 0, 8'h00, 4'h0, 0, 0, 8'h00, 1, 1, 8'h40, 0);
        add(0, 8'h05, 1, 8'h05, 4'h0, 1, 0, 8'h00, 1, 1, 8'h40, 1);
        add(0, 8'h05, 0, 8'h00, 4'h0, 0, 0, 8'h00, 1, 1, 8'h40, 0);
        // Saturation at 0x03.
        for (int i = 0; i < 5; i++) add(0, 8'h03, 1, 8'h03, 4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(0, 8'h03, 0, 8'h00, 4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(0, 8'h03, 1, 8'h03, 4'h0, 1, 1, 8'h33, 0, 0, 8'h00, 0);
        add(0, 8'h03, 1, 8'h03, 4'h0, 1, 1, 8'h33, 0, 1, 8'h33, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h03, 1, 8'h03, 4'h0, 1, 1, 8'h33, 1, 1, 8'h33, 0);
        add(0, 8'h03, 0, 8'h00, 4'h0, 0, 0, 8'h00, 1, 1, 8'h33, 0);
        add(0, 8'h03, 1, 8'h03, 4'h0, 1, 0, 8'h00, 1, 1, 8'h33, 1);
        add(0, 8'h03, 0, 8'h00, 4'h0, 0, 0, 8'h00, 1, 1, 8'h33, 0);
        // BTB tag replacement and aliasing at index 5.
        add(0, 8'h25, 1, 8'h25, 4'h0, 1, 1, 8'h80, 1, 0, 8'h00, 0);
        add(0, 8'h25, 0, 8'h00, 4'h0, 0, 0, 8'h00, 1, 1, 8'h80, 0);
        add(0, 8'h15, 0, 8'h00, 4'h0, 0, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 8'h05, 0, 8'h00, 4'h0, 0, 0, 8'h00, 1, 0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pv, vecs[i].ppc, vecs[i].uv, vecs[i].upc, vecs[i].ughr,
                  vecs[i].upt, vecs[i].ut, vecs[i].utgt);
            step();
            check($sformatf("vec%0d_ready", i), obs[15], 1);
            check($sformatf("vec%0d_taken", i), obs[14], vecs[i].e_taken);
            check($sformatf("vec%0d_hit", i), obs[13], vecs[i].e_hit);
            check($sformatf("vec%0d_target", i), obs[12:5], vecs[i].e_tgt);
            check($sformatf("vec%0d_flush", i), obs[0], vecs[i].e_flush);
        end
        idle();

        // History recovery: train 0x08, 0x09, 0x0B weakly taken, predict three times, then mispredict.
        drive(0, 8'h00, 1, 8'h08, 4'h0, 1, 1, 8'h11); step();
        drive(0, 8'h00, 1, 8'h09, 4'h0, 1, 1, 8'h11); step();
        drive(0, 8'h00, 1, 8'h0B, 4'h0, 1, 1, 8'h11); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h08, 0, 8'h00, 4'h0, 0, 0, 8'h00);
            step();
            check($sformatf("ghr_spec%0d_taken", i), obs[14], 1);
        end
        drive(1, 8'h08, 1, 8'h0C, 4'b0001, 1, 0, 8'h00);
        step();
        check("ghr_before_recover", obs[4:1], GSHARE ? 4'b0111 : 4'b0000);
        check("ghr_recover_flush", obs[0], 1);
        idle();
        step();
        check("ghr_after_recover", obs[4:1], GSHARE ? 4'b0010 : 4'b0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end

        // Reset after training must return every counter to weakly-not-taken and empty the BTB.
        reset_and_wait("runreset");
        scan_clean("cleared");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
